// File: rtl/bit_scan_pkg.sv
// ============================================================================
// bit_scan_pkg : shared enums for the sequential bit scanner  (rev 1.0)
// ============================================================================
`default_nettype none

package bit_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  typedef enum logic {
    MATCH_ONES  = 1'b0,
    MATCH_ZEROS = 1'b1
  } scan_mode_e;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } scan_dir_e;

endpackage

`default_nettype wire

// File: rtl/bit_scanner_seq_if.sv
// ============================================================================
// bit_scanner_seq_if : request/result bundle of the bit scanner  (rev 1.0)
// ============================================================================
`default_nettype none

interface bit_scanner_seq_if #(
  parameter int WIDTH = 10
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] input_vector;
  logic             mode;
  logic             msb_first;
  logic             busy;
  logic             bit_valid;
  logic [IDX_W-1:0] current_index;
  logic             cur_bit;
  logic             is_match;
  logic             done;
  logic [CNT_W-1:0] match_count;
  logic [IDX_W-1:0] first_idx;
  logic             first_valid;

  modport master (
    output start, input_vector, mode, msb_first,
    input  busy, bit_valid, current_index, cur_bit, is_match, done,
           match_count, first_idx, first_valid
  );

  modport slave (
    input  start, input_vector, mode, msb_first,
    output busy, bit_valid, current_index, cur_bit, is_match, done,
           match_count, first_idx, first_valid
  );
endinterface

`default_nettype wire

// File: rtl/bit_scan_index_ctr.sv
// ============================================================================
// bit_scan_index_ctr : loadable up/down index counter, terminal flag (rev 1.0)
// ============================================================================
`default_nettype none

module bit_scan_index_ctr
  import bit_scan_pkg::*;
#(
  parameter  int WIDTH = 10,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load_i,
  input  scan_dir_e             dir_i,
  input  wire logic             step_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  term_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  scan_dir_e        dir_q;

  assign term_o = (dir_q == MSB_FIRST) ? (idx_q == '0) : (idx_q == LAST_IDX);
  assign idx_o  = idx_q;

  // Stepping is suppressed at the terminal index so the count never wraps.
  always_comb begin
    idx_d = idx_q;
    if (load_i) begin
      idx_d = (dir_i == MSB_FIRST) ? LAST_IDX : '0;
    end else if (step_i && !term_o) begin
      idx_d = (dir_q == MSB_FIRST) ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      dir_q <= LSB_FIRST;
    end else begin
      idx_q <= idx_d;
      if (load_i) begin
        dir_q <= dir_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bit_scanner_seq.sv
// ============================================================================
// bit_scanner_seq : walks a captured vector one bit per clock and counts
// polarity matches. Option: BIT_SCANNER_EARLY_EXIT_EN stops at first match.
// ============================================================================
`default_nettype none

module bit_scanner_seq
  import bit_scan_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input wire logic            clk,
  input wire logic            rst_n,
  bit_scanner_seq_if.slave    bus
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  scan_state_e      state_q;
  logic [WIDTH-1:0] vec_q;
  scan_mode_e       mode_q;
  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] first_idx_q;
  logic             first_valid_q;

  logic [IDX_W-1:0] w_idx;
  logic             w_term;
  logic             w_accept;
  logic             w_cur_bit;
  logic             w_match;
  logic             w_last;
  logic             w_step;

  assign w_accept  = (state_q == ST_IDLE) && bus.start;
  assign w_cur_bit = vec_q[w_idx];
  assign w_match   = w_cur_bit ^ (mode_q == MATCH_ZEROS);

`ifdef BIT_SCANNER_EARLY_EXIT_EN
  assign w_last = w_term || w_match;
`else
  assign w_last = w_term;
`endif

  assign w_step = (state_q == ST_SCAN) && !w_last;

  bit_scan_index_ctr #(
    .WIDTH (WIDTH)
  ) u_idx (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (w_accept),
    .dir_i  (scan_dir_e'(bus.msb_first)),
    .step_i (w_step),
    .idx_o  (w_idx),
    .term_o (w_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      vec_q         <= '0;
      mode_q        <= MATCH_ONES;
      count_q       <= '0;
      first_idx_q   <= '0;
      first_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            vec_q         <= bus.input_vector;
            mode_q        <= scan_mode_e'(bus.mode);
            count_q       <= '0;
            first_idx_q   <= '0;
            first_valid_q <= 1'b0;
            state_q       <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_match) begin
            count_q <= count_q + CNT_W'(1);
            if (!first_valid_q) begin
              first_idx_q   <= w_idx;
              first_valid_q <= 1'b1;
            end
          end
          if (w_last) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.bit_valid     = (state_q == ST_SCAN);
  assign bus.done          = (state_q == ST_DONE);
  assign bus.current_index = w_idx;
  assign bus.cur_bit       = w_cur_bit;
  assign bus.is_match      = w_match;
  assign bus.match_count   = count_q;
  assign bus.first_idx     = first_idx_q;
  assign bus.first_valid   = first_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_scanner_seq.sv
// ============================================================================
// tb_bit_scanner_seq : randomized self-checking bench for bit_scanner_seq
// ============================================================================
`default_nettype none

module tb_bit_scanner_seq;

  localparam int W     = 10;
  localparam int IDX_W = $clog2(W);
  localparam int CNT_W = $clog2(W + 1);

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bit_scanner_seq_if #(.WIDTH(W)) bus ();

  bit_scanner_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    checks++;
    if (bus.busy !== 1'b0 || bus.bit_valid !== 1'b0 || bus.done !== 1'b0 ||
        bus.current_index !== '0 || bus.match_count !== '0 ||
        bus.first_idx !== '0 || bus.first_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s got busy=%b valid=%b done=%b idx=%0d cnt=%0d fidx=%0d fv=%b required all zero",
               tag, bus.busy, bus.bit_valid, bus.done, bus.current_index,
               bus.match_count, bus.first_idx, bus.first_valid);
    end
  endtask

  // Reference: walk the positions in scan order with plain integer arithmetic.
  task automatic run_scan(input logic [W-1:0] vec, input logic md, input logic msb,
                          input string tag);
    int   cnt;
    int   fi;
    logic fv;
    int   idx;
    logic b;
    logic m;
    logic last;
    bus.input_vector = vec;
    bus.mode         = md;
    bus.msb_first    = msb;
    bus.start        = 1'b1;
    tick();
    cnt = 0;
    fi  = 0;
    fv  = 1'b0;
    for (int p = 0; p < W; p++) begin
      idx = msb ? (W - 1 - p) : p;
      b   = vec[idx];
      m   = b ^ md;
      checks++;
      if (bus.bit_valid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
          bus.current_index !== IDX_W'(idx) || bus.cur_bit !== b || bus.is_match !== m) begin
        errors++;
        $display("FAIL %s_bit p=%0d got v=%b busy=%b done=%b idx=%0d bit=%b m=%b required v=1 busy=1 done=0 idx=%0d bit=%b m=%b",
                 tag, p, bus.bit_valid, bus.busy, bus.done, bus.current_index,
                 bus.cur_bit, bus.is_match, idx, b, m);
      end
      checks++;
      if (bus.match_count !== CNT_W'(cnt) || bus.first_valid !== fv ||
          bus.first_idx !== IDX_W'(fi)) begin
        errors++;
        $display("FAIL %s_run p=%0d got cnt=%0d fv=%b fidx=%0d required cnt=%0d fv=%b fidx=%0d",
                 tag, p, bus.match_count, bus.first_valid, bus.first_idx, cnt, fv, fi);
      end
      if (m) begin
        if (!fv) begin
          fv = 1'b1;
          fi = idx;
        end
        cnt++;
      end
      last = (p == W - 1);
`ifdef BIT_SCANNER_EARLY_EXIT_EN
      if (m) last = 1'b1;
`endif
      // Scrambled inputs after capture must not disturb the scan.
      bus.input_vector = W'($urandom);
      bus.mode         = 1'($urandom);
      bus.msb_first    = 1'($urandom);
      bus.start        = 1'($urandom);
      if (last) break;
      tick();
    end
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.bit_valid !== 1'b0 ||
        bus.match_count !== CNT_W'(cnt) || bus.first_valid !== fv ||
        bus.first_idx !== IDX_W'(fi)) begin
      errors++;
      $display("FAIL %s_done got done=%b busy=%b v=%b cnt=%0d fv=%b fidx=%0d required done=1 busy=1 v=0 cnt=%0d fv=%b fidx=%0d",
               tag, bus.done, bus.busy, bus.bit_valid, bus.match_count,
               bus.first_valid, bus.first_idx, cnt, fv, fi);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.match_count !== CNT_W'(cnt) ||
        bus.first_idx !== IDX_W'(fi) || bus.first_valid !== fv) begin
      errors++;
      $display("FAIL %s_hold got done=%b busy=%b cnt=%0d fidx=%0d fv=%b required done=0 busy=0 cnt=%0d fidx=%0d fv=%b",
               tag, bus.done, bus.busy, bus.match_count, bus.first_idx,
               bus.first_valid, cnt, fi, fv);
    end
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.input_vector = '0;
    bus.mode         = 1'b0;
    bus.msb_first    = 1'b0;
    repeat (3) tick();
    check_idle_zero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle_zero("reset_release");
  endtask

  task automatic test_directed();
    run_scan(10'b1011001001, 1'b0, 1'b0, "lsb_ones");
`ifndef BIT_SCANNER_EARLY_EXIT_EN
    checks++;
    if (bus.match_count !== CNT_W'(5) || bus.first_idx !== IDX_W'(0) || bus.first_valid !== 1'b1) begin
      errors++;
      $display("FAIL lsb_ones_final got cnt=%0d fidx=%0d fv=%b required 5 0 1",
               bus.match_count, bus.first_idx, bus.first_valid);
    end
    run_scan(10'b1011001001, 1'b0, 1'b1, "msb_ones");
    checks++;
    if (bus.match_count !== CNT_W'(5) || bus.first_idx !== IDX_W'(9)) begin
      errors++;
      $display("FAIL msb_ones_final got cnt=%0d fidx=%0d required 5 9",
               bus.match_count, bus.first_idx);
    end
    run_scan(10'b1011001001, 1'b1, 1'b0, "lsb_zeros");
    checks++;
    if (bus.match_count !== CNT_W'(5) || bus.first_idx !== IDX_W'(1)) begin
      errors++;
      $display("FAIL lsb_zeros_final got cnt=%0d fidx=%0d required 5 1",
               bus.match_count, bus.first_idx);
    end
`else
    run_scan(10'b0000001000, 1'b0, 1'b0, "early_bit3");
    checks++;
    if (bus.match_count !== CNT_W'(1) || bus.first_idx !== IDX_W'(3)) begin
      errors++;
      $display("FAIL early_bit3_final got cnt=%0d fidx=%0d required 1 3",
               bus.match_count, bus.first_idx);
    end
    run_scan(10'b1000000000, 1'b0, 1'b0, "early_bit9");
`endif
    run_scan(10'b0000000000, 1'b0, 1'b0, "no_match");
    checks++;
    if (bus.match_count !== '0 || bus.first_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_match_final got cnt=%0d fv=%b required 0 0",
               bus.match_count, bus.first_valid);
    end
    run_scan(10'b1111111111, 1'b1, 1'b1, "all_ones_zmode");
    run_scan(10'b1111111111, 1'b0, 1'b1, "all_ones_msb");
  endtask

  task automatic test_abort();
    bus.input_vector = 10'b0101010101;
    bus.mode         = 1'b0;
    bus.msb_first    = 1'b0;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.current_index !== IDX_W'(4) || bus.bit_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_ignore_start got idx=%0d v=%b required idx=4 v=1",
               bus.current_index, bus.bit_valid);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_zero("abort_immediate");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle_zero("abort_no_done");
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle_zero("abort_release");
    run_scan(10'b1011001001, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      run_scan(W'($urandom), 1'($urandom), 1'($urandom), "rand");
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
